// File: rtl/ppu_flags_gen.sv
// PPU dot/scanline tracker that snoops $2000/$2001 writes and drives the packed
// ppuflags bus shared by all mapper blocks, plus frame parity and a vblank-start pulse.
module ppu_flags_gen #(
    parameter int unsigned LAST_LINE = 260,
    parameter bit          ODD_SKIP  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_ain,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_din,
    output logic [19:0] ppuflags,
    output logic        frame_odd,
    output logic        vblank_start
);

    localparam logic [8:0] PRE_LINE    = 9'h1FF;
    localparam logic [8:0] LAST_SL     = 9'(LAST_LINE);
    localparam logic [8:0] LAST_DOT    = 9'd340;
    localparam logic [8:0] SKIP_DOT    = 9'd339;
    localparam logic [8:0] VBL_LINE    = 9'd241;
    localparam logic [8:0] FRAME_LINES = 9'd240;
    localparam bit         HAS_VBLANK  = (LAST_LINE >= 241);

    typedef struct packed {
        logic [8:0] cycle;
        logic [8:0] scanline;
        logic       sprite16;
        logic       render_en;
        logic       frame_odd;
        logic       in_frame;
        logic       vblank_start;
    } state_t;

    state_t state_q, state_d;
    logic   skip_line;
    logic   line_end;
    logic   reg_sel;

    // The skip decision looks at the registered render_en, so a $2001 write on dot 339 is too late.
    assign skip_line = ODD_SKIP && (state_q.scanline == PRE_LINE) && state_q.frame_odd
                       && state_q.render_en;
    assign line_end  = (state_q.cycle == LAST_DOT) || (skip_line && (state_q.cycle == SKIP_DOT));
    assign reg_sel   = cpu_write && (cpu_ain[15:13] == 3'b001);

    always_comb begin
        // NOTE: assigning the whole struct first guarantees no latch for any field.
        state_d              = state_q;
        state_d.vblank_start = 1'b0;

        if (ce) begin
            if (line_end) begin
                state_d.cycle = 9'd0;
                if (state_q.scanline == PRE_LINE) begin
                    state_d.scanline  = 9'd0;
                    state_d.frame_odd = ~state_q.frame_odd;
                end else if (state_q.scanline == LAST_SL) begin
                    state_d.scanline = PRE_LINE;
                end else begin
                    state_d.scanline = state_q.scanline + 9'd1;
                end
            end else begin
                state_d.cycle = state_q.cycle + 9'd1;
            end

            if (reg_sel && (cpu_ain[2:0] == 3'd0)) begin
                state_d.sprite16 = cpu_din[5];
            end
            if (reg_sel && (cpu_ain[2:0] == 3'd1)) begin
                state_d.render_en = cpu_din[3] | cpu_din[4];
            end

            state_d.vblank_start = HAS_VBLANK && (state_d.scanline == VBL_LINE)
                                   && (state_d.cycle == 9'd1);
        end

        // Pre-render (9'h1FF) compares as >= 240, so it is never in frame.
        state_d.in_frame = state_d.render_en && (state_d.scanline < FRAME_LINES);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign ppuflags     = {state_q.scanline, state_q.cycle, state_q.sprite16, state_q.in_frame};
    assign frame_odd    = state_q.frame_odd;
    assign vblank_start = state_q.vblank_start;

endmodule

// File: tb/tb_ppu_flags_gen.sv
// Self-checking bench for ppu_flags_gen: a default-size instance and a short-frame
// instance (LAST_LINE=5) run side by side against a line-length based position model.
module tb_ppu_flags_gen;

    localparam int BIG_LAST   = 260;
    localparam int SMALL_LAST = 5;

    typedef struct {
        int line;   // -1 stands for the pre-render line
        int dot;
        bit odd;
        bit ren;
        bit spr;
        bit inf;
        bit vbs;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        b_rst_n = 1'b0, b_ce = 1'b0, b_wr = 1'b0;
    logic [15:0] b_ain = 16'h0;
    logic [7:0]  b_din = 8'h0;
    logic [19:0] b_flags;
    logic        b_odd, b_vbs;

    logic        s_rst_n = 1'b0, s_ce = 1'b0, s_wr = 1'b0;
    logic [15:0] s_ain = 16'h0;
    logic [7:0]  s_din = 8'h0;
    logic [19:0] s_flags;
    logic        s_odd, s_vbs;

    ppu_flags_gen u_big (
        .clk(clk), .reset(b_rst_n), .ce(b_ce), .cpu_ain(b_ain), .cpu_write(b_wr),
        .cpu_din(b_din), .ppuflags(b_flags), .frame_odd(b_odd), .vblank_start(b_vbs)
    );

    ppu_flags_gen #(.LAST_LINE(SMALL_LAST), .ODD_SKIP(1'b1)) u_small (
        .clk(clk), .reset(s_rst_n), .ce(s_ce), .cpu_ain(s_ain), .cpu_write(s_wr),
        .cpu_din(s_din), .ppuflags(s_flags), .frame_odd(s_odd), .vblank_start(s_vbs)
    );

    int      n_tests = 0;
    int      n_fail  = 0;
    bit      chk_en  = 1'b0;
    mstate_t m_b     = '{default: 0};
    mstate_t m_s     = '{default: 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One dot of the line-length model: a line holds 341 dots, 340 on an odd
    // frame's pre-render line when rendering was already on.
    function automatic mstate_t mstep(input mstate_t s, input bit rst_n, input bit ce,
                                      input bit wr, input logic [15:0] a, input logic [7:0] d,
                                      input int last_line);
        mstate_t n;
        int      len;
        n = s;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        n.vbs = 1'b0;
        if (!ce) return n;
        len = (s.line == -1 && s.odd && s.ren) ? 340 : 341;
        if (s.dot + 1 >= len) begin
            n.dot = 0;
            if (s.line == -1) begin
                n.line = 0;
                n.odd  = !s.odd;
            end else if (s.line == last_line) begin
                n.line = -1;
            end else begin
                n.line = s.line + 1;
            end
        end else begin
            n.dot = s.dot + 1;
        end
        if (wr && a[15:13] == 3'b001 && a[2:0] == 3'd0) n.spr = d[5];
        if (wr && a[15:13] == 3'b001 && a[2:0] == 3'd1) n.ren = d[3] | d[4];
        n.inf = n.ren && n.line >= 0 && n.line < 240;
        n.vbs = (n.line == 241 && n.dot == 1);
        return n;
    endfunction

    function automatic logic [19:0] flags_of(input mstate_t s);
        logic [8:0] pl;
        pl = (s.line < 0) ? 9'h1FF : 9'(s.line);
        return {pl, 9'(s.dot), s.spr, s.inf};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_b = mstep(m_b, b_rst_n, b_ce, b_wr, b_ain, b_din, BIG_LAST);
            m_s = mstep(m_s, s_rst_n, s_ce, s_wr, s_ain, s_din, SMALL_LAST);
            #1;
            if (chk_en) begin
                check("big_flags", 32'(b_flags), 32'(flags_of(m_b)));
                check("big_odd", 32'(b_odd), 32'(m_b.odd));
                check("big_vblank", 32'(b_vbs), 32'(m_b.vbs));
                check("small_flags", 32'(s_flags), 32'(flags_of(m_s)));
                check("small_odd", 32'(s_odd), 32'(m_s.odd));
                check("small_vblank", 32'(s_vbs), 32'(m_s.vbs));
            end
        end
    end

    task automatic b_cycle(input bit rst_n, input bit ce, input bit wr,
                           input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        b_rst_n = rst_n; b_ce = ce; b_wr = wr; b_ain = a; b_din = d;
        @(posedge clk);
        #2;
    endtask

    task automatic s_cycle(input bit rst_n, input bit ce, input bit wr,
                           input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        s_rst_n = rst_n; s_ce = ce; s_wr = wr; s_ain = a; s_din = d;
        @(posedge clk);
        #2;
    endtask

    task automatic b_run_to(input int line, input int dot);
        int         n = 0;
        logic [8:0] pl;
        while (!(m_b.line == line && m_b.dot == dot) && n < 90000) begin
            b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
            n++;
        end
        pl = (line < 0) ? 9'h1FF : 9'(line);
        check("big_reach_pos", 32'(b_flags[19:2]), 32'({pl, 9'(dot)}));
    endtask

    task automatic s_run_to(input int line, input int dot);
        int         n = 0;
        logic [8:0] pl;
        while (!(m_s.line == line && m_s.dot == dot) && n < 5000) begin
            s_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
            n++;
        end
        pl = (line < 0) ? 9'h1FF : 9'(line);
        check("small_reach_pos", 32'(s_flags[19:2]), 32'({pl, 9'(dot)}));
    endtask

    // Counts dots from frame start until frame_odd flips; optional write on the first dot.
    task automatic s_measure(input bit wr, input logic [7:0] d, input int exp_len,
                             input string name);
        int   n = 0;
        logic prev;
        prev = s_odd;
        s_cycle(1'b1, 1'b1, wr, 16'h2001, d);
        n++;
        while (s_odd === prev && n < 3000) begin
            s_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
            n++;
        end
        check(name, 32'(n), 32'(exp_len));
    endtask

    task automatic big_seq();
        int vb = 0;
        int n  = 0;
        bit ce_t = 1'b0;
        b_cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        b_cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        check("reset_flags", 32'(b_flags), 32'h0);
        check("reset_odd", 32'(b_odd), 32'h0);

        repeat (340) b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        check("dot340", 32'(b_flags), 32'h00550);
        b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        check("dot341_wrap", 32'(b_flags), 32'h00800);

        b_cycle(1'b1, 1'b1, 1'b1, 16'h2008, 8'h20);
        check("spr_mirror_set", 32'(b_flags[1]), 32'h1);
        b_cycle(1'b1, 1'b1, 1'b1, 16'h2000, 8'h00);
        check("spr_clear", 32'(b_flags[1]), 32'h0);
        b_cycle(1'b1, 1'b1, 1'b1, 16'h4000, 8'h20);
        check("spr_4000_ignored", 32'(b_flags[1]), 32'h0);
        b_cycle(1'b1, 1'b0, 1'b1, 16'h3FF8, 8'h20);
        check("spr_no_ce_ignored", 32'(b_flags[1]), 32'h0);
        b_cycle(1'b1, 1'b1, 1'b1, 16'h200A, 8'h20);
        check("spr_2002_ignored", 32'(b_flags[1]), 32'h0);

        b_cycle(1'b1, 1'b1, 1'b1, 16'h2001, 8'h18);
        check("render_on_inframe", 32'(b_flags[0]), 32'h1);
        b_run_to(100, 170);
        b_cycle(1'b1, 1'b1, 1'b1, 16'h2009, 8'h00);
        check("render_off_l100", 32'(b_flags[0]), 32'h0);
        b_cycle(1'b1, 1'b1, 1'b1, 16'h2001, 8'h08);
        check("render_bit3_on", 32'(b_flags[0]), 32'h1);

        b_run_to(239, 340);
        check("inframe_l239", 32'(b_flags[0]), 32'h1);
        b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        check("line240_flags", 32'(b_flags), 32'h78000);

        b_run_to(240, 330);
        while (!(m_b.line == 241 && m_b.dot == 5) && n < 100) begin
            ce_t = ~ce_t;
            b_cycle(1'b1, ce_t, 1'b0, 16'h0, 8'h0);
            if (b_vbs === 1'b1) vb++;
            n++;
        end
        check("vblank_one_clock", 32'(vb), 32'd1);
        check("half_ce_pos", 32'(b_flags[19:2]), 32'({9'd241, 9'd5}));

        b_cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("midframe_reset", 32'(b_flags), 32'h0);
        b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        check("post_reset_dot1", 32'(b_flags), 32'h00004);
    endtask

    task automatic small_seq();
        s_cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        s_cycle(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        check("small_reset_flags", 32'(s_flags), 32'h0);

        s_measure(1'b0, 8'h00, 2387, "frame0_even_off");
        check("frame0_parity", 32'(s_odd), 32'h1);
        s_measure(1'b0, 8'h00, 2387, "frame1_odd_off");
        s_measure(1'b1, 8'h18, 2387, "frame2_even_on");
        s_measure(1'b0, 8'h00, 2386, "frame3_odd_skip");
        s_measure(1'b0, 8'h00, 2387, "frame4_even_on");

        s_run_to(-1, 339);
        s_cycle(1'b1, 1'b1, 1'b1, 16'h2001, 8'h00);
        check("skip_late_off", 32'(s_flags), 32'h0);
        check("skip_late_off_par", 32'(s_odd), 32'h0);

        s_run_to(-1, 339);
        s_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        s_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        s_run_to(-1, 339);
        s_cycle(1'b1, 1'b1, 1'b1, 16'h2001, 8'h18);
        check("no_skip_late_on", 32'(s_flags), 32'hFFD50);
        s_cycle(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
        check("late_on_line0", 32'(s_flags), 32'h00001);
    endtask

    initial begin
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        fork
            big_seq();
            small_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
